// File: rtl/aes_core_arbiter.sv
// Two-requester arbiter sharing one AES core; one job in flight, response held until accepted.
// Define AES_ARB_RR_EN for round-robin grant; default build is fixed priority (requester 0 wins).
module aes_core_arbiter #(
    parameter int unsigned CORE_LAT = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [1:0]   req_valid_i,
    output logic [1:0]   req_ready_o,
    input  logic [255:0] req_key_i,
    input  logic [255:0] req_text_i,
    output logic [1:0]   rsp_valid_o,
    input  logic [1:0]   rsp_ready_i,
    output logic [127:0] rsp_data_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_text_o,
    input  logic [127:0] core_cipher_i,
    output logic         busy_o
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [7:0] LatInit = 8'(CORE_LAT - 1);

    state_e       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         grant_q, grant_d;
    logic [1:0]   rsp_valid_q, rsp_valid_d;
    logic [127:0] rsp_data_q, rsp_data_d;
    logic [127:0] key_q, key_d;
    logic [127:0] text_q, text_d;
    logic         gnt_idx;
    logic         accept;

`ifdef AES_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        if (req_valid_i == 2'b11) begin
            gnt_idx = ~last_q;
        end else begin
            gnt_idx = req_valid_i[1];
        end
    end
`else
    always_comb gnt_idx = ~req_valid_i[0];
`endif

    assign accept      = (state_q == StIdle) && (req_valid_i != 2'b00);
    assign req_ready_o = accept ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        key_d       = key_q;
        text_d      = text_q;
`ifdef AES_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    key_d   = gnt_idx ? req_key_i[255:128] : req_key_i[127:0];
                    text_d  = gnt_idx ? req_text_i[255:128] : req_text_i[127:0];
                    grant_d = gnt_idx;
                    cnt_d   = LatInit;
                    state_d = StWait;
`ifdef AES_ARB_RR_EN
                    last_d  = gnt_idx;
`endif
                end
            end
            StWait: begin
                if (cnt_q == 8'd0) begin
                    rsp_data_d  = core_cipher_i;
                    rsp_valid_d = grant_q ? 2'b10 : 2'b01;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StResp: begin
                // Only the granted requester's ready can release the response.
                if (rsp_ready_i[grant_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            grant_q     <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            key_q       <= '0;
            text_q      <= '0;
`ifdef AES_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            key_q       <= key_d;
            text_q      <= text_d;
`ifdef AES_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign core_key_o  = key_q;
    assign core_text_o = text_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: grant table, job table, backpressure, mid-job reset and
// continuous contention; responses are checked against a scoreboard queue.
module tb_aes_core_arbiter;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [255:0] req_key, req_text;
    logic [127:0] rsp_data, core_key, core_text, core_cipher;
    logic         busy;
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;

    typedef struct {
        logic         r;
        logic [127:0] data;
        int           acc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [1:0] v;
        logic [1:0] exp_ready;
    } gnt_vec_t;

    typedef struct {
        logic         r;
        logic [127:0] key;
        logic [127:0] text;
        int           hold;
    } job_t;

    aes_core_arbiter #(.CORE_LAT(LAT)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_key_i    (req_key),
        .req_text_i   (req_text),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .core_key_o   (core_key),
        .core_text_o  (core_text),
        .core_cipher_i(core_cipher),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stub: XOR of key and text, delayed LAT-1 cycles.
    generate
        if (LAT == 1) begin : g_comb
            assign core_cipher = core_key ^ core_text;
        end else begin : g_pipe
            logic [127:0] pipe [LAT-1];
            always @(posedge clk) begin
                pipe[0] <= core_key ^ core_text;
                for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
            end
            assign core_cipher = pipe[LAT-2];
        end
    endgenerate

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic [127:0] data, input int acc);
        exp_t e;
        e.r    = r;
        e.data = data;
        e.acc  = acc;
        sbq.push_back(e);
    endtask

    task automatic set_slot(input logic r, input logic [127:0] key, input logic [127:0] text);
        if (r) begin
            req_key[255:128]  = key;
            req_text[255:128] = text;
        end else begin
            req_key[127:0]  = key;
            req_text[127:0] = text;
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (rsp_valid == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid == 2'b00) chk("rsp_timeout", 128'(n), 128'(LAT));
    endtask

    task automatic run_job(input job_t j);
        logic [1:0] one;
        one = j.r ? 2'b10 : 2'b01;
        set_slot(j.r, j.key, j.text);
        set_slot(~j.r, ~j.key, ~j.text);
        req_valid = one;
        rsp_ready = 2'b00;
        #1;
        chk("job_ready", 128'(req_ready), 128'(one));
        push(j.r, j.key ^ j.text, cyc + 1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("job_busy", 128'(busy), 128'(1'b1));
        chk("job_core_key", core_key, j.key);
        chk("job_core_text", core_text, j.text);
        wait_rsp();
        for (int i = 0; i < j.hold; i++) begin
            rsp_ready = ~one;
            req_valid = 2'b11;
            @(negedge clk);
            chk("hold_valid", 128'(rsp_valid), 128'(one));
            chk("hold_data", rsp_data, j.key ^ j.text);
            chk("hold_no_ready", 128'(req_ready), 128'(0));
        end
        rsp_ready = one;
        req_valid = 2'b00;
        @(negedge clk);
        chk("ack_valid", 128'(rsp_valid), 128'(0));
        chk("ack_busy", 128'(busy), 128'(0));
        chk("ack_key_held", core_key, j.key);
        rsp_ready = 2'b00;
    endtask

    // Scoreboard monitor: every rising response must match the next expected job.
    initial begin
        logic [1:0] prev;
        exp_t e;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if (rsp_valid == 2'b11) chk("rsp_both", 128'(rsp_valid), 128'(0));
            if (rsp_valid != 2'b00 && prev == 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_idx", 128'(rsp_valid), 128'(e.r ? 2'b10 : 2'b01));
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_latency", 128'(cyc), 128'(e.acc + LAT));
                end
            end
            prev = rsp_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=<200000", $time);
        $fatal(1);
    end

    initial begin
        gnt_vec_t gv[4];
        job_t     jobs[3];
        job_t     jb;
        logic [127:0] k0, t0, k1, t1;
        int c;

        gv[0] = '{2'b00, 2'b00};
        gv[1] = '{2'b01, 2'b01};
        gv[2] = '{2'b10, 2'b10};
        gv[3] = '{2'b11, 2'b01};
        jobs[0] = '{1'b0, 128'he01fc9945862fdd9cba66f451f0621e3,
                    128'h004e7d60cde97ae9d3ebf5271779482e, 2};
        jobs[1] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734, 0};
        jobs[2] = '{1'b0, 128'hffffffffffffffff0000000000000000,
                    128'h0123456789abcdeffedcba9876543210, 3};
        k0 = 128'h11112222333344445555666677778888;
        t0 = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
        k1 = 128'hcafebabedeadbeef0123456789abcdef;
        t1 = 128'h00000000ffffffff00000000ffffffff;

        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_key   = {128'hdead, 128'hbeef};
        req_text  = {128'h1234, 128'h5678};
        @(negedge clk);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_data", rsp_data, 128'(0));
        chk("rst_core_key", core_key, 128'(0));
        chk("rst_core_text", core_text, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ready", 128'(req_ready), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            req_valid = gv[i].v;
            #1;
            chk("idle_grant", 128'(req_ready), 128'(gv[i].exp_ready));
        end
        req_valid = 2'b00;
        @(negedge clk);

        for (int i = 0; i < 3; i++) run_job(jobs[i]);

        // Backpressure on requester 1 while requester 0 waits.
        jb = '{1'b1, k1, t1, 0};
        set_slot(1'b1, k1, t1);
        set_slot(1'b0, k0, t0);
        req_valid = 2'b10;
        push(1'b1, k1 ^ t1, cyc + 1);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp();
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 128'(rsp_valid), 128'(2'b10));
            chk("bp_data", rsp_data, jb.key ^ jb.text);
            chk("bp_no_ready", 128'(req_ready), 128'(0));
        end
        rsp_ready = 2'b10;
        push(1'b0, k0 ^ t0, cyc + 2);
        @(negedge clk);
        rsp_ready = 2'b00;
        chk("bp_exit_valid", 128'(rsp_valid), 128'(0));
        chk("bp_exit_ready", 128'(req_ready), 128'(2'b01));
        @(negedge clk);
        req_valid = 2'b00;
        chk("bp_accept_busy", 128'(busy), 128'(1));
        chk("bp_accept_key", core_key, k0);
        wait_rsp();
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;

        // Reset in WAIT with two cycles left: the job must vanish without a response.
        set_slot(1'b1, k1, t1);
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        chk("abort_busy_pre", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("abort_rsp_data", rsp_data, 128'(0));
        chk("abort_core_key", core_key, 128'(0));
        chk("abort_core_text", core_text, 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_idle", 128'(busy), 128'(0));

        // Continuous contention: accepts every LAT+2 cycles.
        set_slot(1'b0, k0, t0);
        set_slot(1'b1, k1, t1);
        c = cyc;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef AES_ARB_RR_EN
            push(k[0], k[0] ? (k1 ^ t1) : (k0 ^ t0), c + 1 + k * (LAT + 2));
`else
            push(1'b0, k0 ^ t0, c + 1 + k * (LAT + 2));
`endif
        end
        for (int i = 0; i < 3 * (LAT + 2) + 1; i++) begin
            @(negedge clk);
`ifndef AES_ARB_RR_EN
            chk("fixed_no_ready1", 128'(req_ready[1]), 128'(0));
`endif
        end
        req_valid = 2'b00;
        repeat (LAT + 4) @(negedge clk);
        rsp_ready = 2'b00;
        chk("sb_empty", 128'(sbq.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
